// File: rtl/nanop_mem_resp_if.sv
// rtl/nanop_mem_resp_if.sv - processor bus, loader stream and output port bundle for nanop_mem_resp
interface nanop_mem_resp_if;
    logic [7:0] addr;
    logic [7:0] data_w;
    logic       write;
    logic [7:0] data_r;
    logic       cpu_hold;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic [7:0] out_port;
    logic       out_strobe;

    modport master (
        output addr,
        output data_w,
        output write,
        input  data_r,
        input  cpu_hold,
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready,
        input  out_port,
        input  out_strobe
    );

    modport slave (
        input  addr,
        input  data_w,
        input  write,
        output data_r,
        output cpu_hold,
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready,
        output out_port,
        output out_strobe
    );
endinterface

// File: rtl/nanop_mem_resp.sv
// rtl/nanop_mem_resp.sv - nanoprocessor memory responder with byte loader and output port (optional NANOP_MEM_RELOAD_EN)
module nanop_mem_resp #(
    parameter int         DEPTH    = 256,
    parameter logic [7:0] OUT_ADDR = 8'hFF
) (
    input logic             clk,
    input logic             reset,
`ifdef NANOP_MEM_RELOAD_EN
    input logic             reload,
`endif
    nanop_mem_resp_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_next;
    logic [AW-1:0] ptr_inc;
    logic          ptr_at_end;
    logic [AW-1:0] bus_idx;
    logic          load_fire;
    logic          run_write;
    logic          out_hit;
    logic          hold;
    logic          ready;
    logic          reload_req;

    logic [7:0]    mem [DEPTH];

    // Addresses beyond the store alias back into it.
    assign bus_idx    = AW'(32'(bus.addr) % 32'(DEPTH));
    assign ptr_at_end = (ptr == AW'(DEPTH - 1));
    assign ptr_inc    = ptr_at_end ? '0 : ptr + AW'(1);
    assign out_hit    = run_write && (bus.addr == OUT_ADDR);

`ifdef NANOP_MEM_RELOAD_EN
    assign reload_req = reload;
`else
    assign reload_req = 1'b0;
`endif

    assign bus.cpu_hold = hold;
    assign bus.ld_ready = ready;

    // State and load pointer; reset restarts loading from address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next state, load pointer and per-cycle strobes.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        load_fire  = 1'b0;
        run_write  = 1'b0;
        hold       = 1'b1;
        ready      = 1'b1;
        case (state)
            ST_LOAD: begin
                hold  = 1'b1;
                ready = 1'b1;
                if (bus.ld_valid) begin
                    load_fire = 1'b1;
                    ptr_next  = ptr_inc;
                    // A full store ends the load even without ld_last.
                    if (bus.ld_last || ptr_at_end) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                hold      = 1'b0;
                ready     = 1'b0;
                run_write = bus.write;
                // The write presented alongside reload still lands.
                if (reload_req) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = ST_LOAD;
                ptr_next   = '0;
            end
        endcase
    end

    // Storage array; contents survive reset so only writes modify it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_fire) begin
                mem[ptr] <= bus.ld_data;
            end else if (run_write) begin
                mem[bus_idx] <= bus.data_w;
            end
        end
    end

    // Registered read port; returns pre-write contents on a same-address write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data_r <= 8'h00;
        end else if (state == ST_RUN) begin
            bus.data_r <= mem[bus_idx];
        end
    end

    // Memory-mapped output port with a one-cycle strobe per write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_port   <= 8'h00;
            bus.out_strobe <= 1'b0;
        end else begin
            bus.out_strobe <= out_hit;
            if (out_hit) begin
                bus.out_port <= bus.data_w;
            end
        end
    end
endmodule

// File: tb/tb_nanop_mem_resp.sv
// tb/tb_nanop_mem_resp.sv - scoreboard testbench for nanop_mem_resp
module tb_nanop_mem_resp;
    logic clk;
    logic reset;
`ifdef NANOP_MEM_RELOAD_EN
    logic reload;
`endif

    nanop_mem_resp_if bus ();

    nanop_mem_resp #(
        .DEPTH    (256),
        .OUT_ADDR (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef NANOP_MEM_RELOAD_EN
        .reload (reload),
`endif
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         chk_rd;
        logic [7:0] exp_data;
        bit         exp_strobe;
        logic [7:0] exp_port;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         bus_act = 1'b0;

    logic [7:0] mem_m   [256];
    bit         known_m [256];
    int         ptr_m   = 0;
    logic [7:0] port_m  = 8'h00;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every bus cycle the DUT saw gets compared one edge later.
    initial begin
        forever begin
            @(posedge clk);
            if (bus_act) begin
                #1;
                if (sb_q.size() == 0) begin
                    check8("sb_underflow", 8'h01, 8'h00);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.chk_rd) check8("data_r", bus.data_r, e.exp_data);
                    check8("out_strobe", {7'd0, bus.out_strobe}, {7'd0, e.exp_strobe});
                    check8("out_port", bus.out_port, e.exp_port);
                end
            end
        end
    end

    task automatic run_cycle(input logic [7:0] a, input bit w, input logic [7:0] d, input bit chk);
        exp_t e;
        @(negedge clk);
        bus.addr   = a;
        bus.write  = w;
        bus.data_w = d;
        bus_act    = 1'b1;
        e.chk_rd     = chk && known_m[a];
        e.exp_data   = mem_m[a];
        e.exp_strobe = w && (a == 8'hFF);
        if (e.exp_strobe) port_m = d;
        e.exp_port   = port_m;
        sb_q.push_back(e);
        if (w) begin
            mem_m[a]   = d;
            known_m[a] = 1'b1;
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.write = 1'b0;
        bus_act   = 1'b0;
`ifdef NANOP_MEM_RELOAD_EN
        reload    = 1'b0;
`endif
    endtask

    task automatic check_reset_state();
        check8("rst_cpu_hold", {7'd0, bus.cpu_hold}, 8'h01);
        check8("rst_ld_ready", {7'd0, bus.ld_ready}, 8'h01);
        check8("rst_data_r", bus.data_r, 8'h00);
        check8("rst_out_port", bus.out_port, 8'h00);
        check8("rst_out_strobe", {7'd0, bus.out_strobe}, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_state();
        @(negedge clk);
        reset  = 1'b0;
        ptr_m  = 0;
        port_m = 8'h00;
    endtask

    task automatic load_byte(input logic [7:0] b, input bit last);
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.ld_valid = 1'b0;
            bus.ld_last  = 1'b0;
            bus.ld_data  = 8'($urandom);
        end
        @(negedge clk);
        check8("load_cpu_hold", {7'd0, bus.cpu_hold}, 8'h01);
        check8("load_ld_ready", {7'd0, bus.ld_ready}, 8'h01);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        bus.ld_last  = last;
        mem_m[ptr_m]   = b;
        known_m[ptr_m] = 1'b1;
        ptr_m = (ptr_m + 1) % 256;
    endtask

    task automatic load_done();
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check8("run_cpu_hold", {7'd0, bus.cpu_hold}, 8'h00);
        check8("run_ld_ready", {7'd0, bus.ld_ready}, 8'h00);
    endtask

    initial begin
        logic [7:0] t1 [4];
        t1 = '{8'h0A, 8'h80, 8'h0B, 8'h81};
        for (int i = 0; i < 256; i++) known_m[i] = 1'b0;
        reset        = 1'b1;
        bus.addr     = 8'h00;
        bus.data_w   = 8'h00;
        bus.write    = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        bus.ld_last  = 1'b0;
`ifdef NANOP_MEM_RELOAD_EN
        reload       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // Short stream terminated by ld_last, then sequential reads.
        for (int i = 0; i < 4; i++) load_byte(t1[i], i == 3);
        load_done();
        check8("data_r_held_in_load", bus.data_r, 8'h00);
        for (int i = 0; i < 4; i++) run_cycle(8'(i), 1'b0, 8'h00, 1'b1);
        bus_idle();

        // Full 256-byte stream without ld_last; implicit end and wrap.
        do_reset();
        for (int i = 0; i < 256; i++) load_byte(8'(i), 1'b0);
        load_done();
        run_cycle(8'hFE, 1'b0, 8'h00, 1'b1);
        run_cycle(8'h00, 1'b0, 8'h00, 1'b1);
        run_cycle(8'h7F, 1'b0, 8'h00, 1'b1);
        bus_idle();

        // Read-during-write returns old contents.
        run_cycle(8'h40, 1'b1, 8'h11, 1'b1);
        run_cycle(8'h40, 1'b1, 8'h5A, 1'b1);
        run_cycle(8'h40, 1'b0, 8'h00, 1'b1);
        bus_idle();

        // Output port: back-to-back strobes, neighbour address ignored.
        run_cycle(8'hFF, 1'b1, 8'h33, 1'b1);
        run_cycle(8'hFF, 1'b1, 8'h44, 1'b1);
        run_cycle(8'hFE, 1'b1, 8'h99, 1'b1);
        run_cycle(8'hFF, 1'b0, 8'h00, 1'b1);
        run_cycle(8'hFE, 1'b0, 8'h00, 1'b1);
        bus_idle();

        // Random bus traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            run_cycle(a, $urandom_range(0, 2) == 0, 8'($urandom), 1'b1);
            if ($urandom_range(0, 9) == 0) bus_idle();
        end
        bus_idle();

        // Reset mid-load, ignored write during LOAD, restart from 0.
        do_reset();
        load_byte(8'hA1, 1'b0);
        load_byte(8'hA2, 1'b0);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        do_reset();
        bus.addr   = 8'h05;
        bus.data_w = 8'hEE;
        bus.write  = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
        check8("load_write_no_strobe", {7'd0, bus.out_strobe}, 8'h00);
        check8("load_write_data_r", bus.data_r, 8'h00);
        load_byte(8'hC0, 1'b1);
        load_done();
        run_cycle(8'h00, 1'b0, 8'h00, 1'b1);
        run_cycle(8'h05, 1'b0, 8'h00, 1'b1);
        run_cycle(8'h01, 1'b0, 8'h00, 1'b1);
        bus_idle();

`ifdef NANOP_MEM_RELOAD_EN
        // Reload with a concurrent write; write completes, LOAD resumes.
        run_cycle(8'h10, 1'b1, 8'h77, 1'b1);
        reload = 1'b1;
        bus_idle();
        check8("reload_cpu_hold", {7'd0, bus.cpu_hold}, 8'h01);
        check8("reload_ld_ready", {7'd0, bus.ld_ready}, 8'h01);
        ptr_m = 0;
        load_byte(8'h5C, 1'b1);
        load_done();
        run_cycle(8'h10, 1'b0, 8'h00, 1'b1);
        run_cycle(8'h00, 1'b0, 8'h00, 1'b1);
        bus_idle();
`else
        // Without reload the same write leaves the processor running.
        run_cycle(8'h10, 1'b1, 8'h77, 1'b1);
        bus_idle();
        check8("norld_cpu_hold", {7'd0, bus.cpu_hold}, 8'h00);
        check8("norld_ld_ready", {7'd0, bus.ld_ready}, 8'h00);
        run_cycle(8'h10, 1'b0, 8'h00, 1'b1);
        bus_idle();
`endif

        repeat (4) @(negedge clk);
        check8("sb_drained", 8'(sb_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nanop_mem_resp.md
Name: nanop_mem_resp

Overview:
Memory-side responder for the nanoprocessor bus. It answers the address, WRITE and accumulator-data signals driven by the processor datapath and controller.
- Holds a 256-byte program/data store with synchronous read and write.
- Provides one memory-mapped output port.
- Provides a byte-stream loader that fills memory while the processor is held. Processor execution starts only after the load completes.

Parameters:
DEPTH, 256, number of 8-bit words; addresses at or above DEPTH alias modulo DEPTH.
OUT_ADDR, 8'hFF, address whose writes also update out_port.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous reset, active-high
addr  in  8  bus address from processor (PC or address register)
data_w  in  8  write data from processor accumulator
write  in  1  write strobe from controller, sampled on rising edge
data_r  out  8  registered read data to processor
cpu_hold  out  1  high while loading; processor must keep its reset/stall asserted
ld_valid  in  1  loader byte valid
ld_data  in  8  loader byte
ld_last  in  1  marks final loader byte; meaningful only with ld_valid
ld_ready  out  1  loader may transfer
out_port  out  8  last value written to OUT_ADDR
out_strobe  out  1  one-cycle pulse on each OUT_ADDR write

Behaviour:
Reset (asynchronous, while reset=1):
- state=LOAD, load pointer=0.
- data_r=0, out_port=0, out_strobe=0, cpu_hold=1, ld_ready=1.
- Memory contents are not cleared.

State LOAD:
- cpu_hold=1, ld_ready=1.
- Transfer occurs when ld_valid && ld_ready at the rising edge: mem[ptr]<=ld_data, ptr<=ptr+1.
- Transition to RUN after a transfer with ld_last=1, or after the transfer at ptr=DEPTH-1 (implicit last; ptr wraps to 0).
- The bus is ignored: write has no effect; data_r holds its value.

State RUN:
- cpu_hold=0, ld_ready=0; ld_valid/ld_data/ld_last are ignored.
- RUN persists until reset (see Optional Feature).
- First RUN cycle: the cycle after the last load transfer.

Read:
- Every RUN cycle, data_r<=mem[addr].
- Latency is 1 cycle: the address presented in cycle n appears on data_r in cycle n+1.

Write:
- write=1 in RUN: mem[addr]<=data_w.
- Read-during-write to the same address returns the OLD contents on data_r; the new value is visible from the following read.

Output port:
- A RUN write with addr==OUT_ADDR additionally sets out_port<=data_w and out_strobe=1 for exactly one cycle.
- The memory at OUT_ADDR is also written, so reads of OUT_ADDR return the last written value.
- Back-to-back writes produce back-to-back strobes, one per write.
- out_port holds its value until the next OUT_ADDR write or reset.

Reset mid-load: loading restarts at address 0. Bytes already written remain but must be overwritten by the new stream.

Optional Feature:
Macro NANOP_MEM_RELOAD_EN.
- Defined: adds input port reload (1 bit). A 1-cycle reload=1 in RUN returns to LOAD at the next edge.
  - ptr=0, cpu_hold=1, ld_ready=1.
  - Any write in that same cycle still completes.
  - reload in LOAD is ignored.
- Not defined: port absent; RUN is left only through reset.

Test Plan:
1. Reset, then stream bytes 8'h0A,8'h80,8'h0B,8'h81 with ld_last on the 4th -> cpu_hold falls the cycle after the 4th transfer. In RUN, addr=0..3 yields data_r 0A,80,0B,81, each one cycle after its address.
2. Stream 256 bytes (value=index), ld_last never asserted -> RUN entered after byte 255. Reading addr=8'hFE returns 8'hFE; ptr wrapped, no extra write to address 0.
3. RUN, write=1 addr=8'h40 data_w=8'h5A while reading 8'h40 (old 8'h11) -> data_r=8'h11 next cycle, then 8'h5A on the following read.
4. RUN, writes 8'h33 then 8'h44 to 8'hFF on consecutive cycles -> out_strobe high two cycles, out_port=33 then 44. Writes to 8'hFE leave out_strobe=0 and out_port unchanged.
5. Assert reset after 2 load bytes, deassert, stream 8'hC0 with ld_last -> mem[0]=8'hC0, RUN entered; write in LOAD with addr=8'h05 data_w=8'hEE has no effect.
6. With NANOP_MEM_RELOAD_EN: in RUN pulse reload together with write to 8'h10 (8'h77) -> cpu_hold=1 and ld_ready=1 next cycle, and mem[8'h10]=8'h77. Without the macro the same stimulus minus reload keeps RUN.
